// File: rtl/core_seq_ctrl_pkg.sv
// Shared encodings for the RV32E multi-cycle sequencer: FSM states, error codes
// and the execute-op codes the decoder hands over.
package core_seq_ctrl_pkg;

  localparam int CTRL_STATE_WIDTH = 3;

  typedef enum logic [CTRL_STATE_WIDTH-1:0] {
    CTRL_RESET  = 3'd0,
    CTRL_FETCH  = 3'd1,
    CTRL_DECODE = 3'd2,
    CTRL_EXEC   = 3'd3,
    CTRL_MEM    = 3'd4,
    CTRL_WB     = 3'd5,
    CTRL_HALT   = 3'd6
  } ctrl_state_e;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_FETCH_TMO = 2'd1;
  localparam logic [1:0] ERR_LSU_TMO   = 2'd2;
  localparam logic [1:0] ERR_EXU       = 2'd3;

  localparam int EXU_OPT_WIDTH = 5;

  localparam logic [EXU_OPT_WIDTH-1:0] EXU_ADD    = 5'd0;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_SUB    = 5'd1;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_AND    = 5'd2;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_OR     = 5'd3;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_XOR    = 5'd4;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_SLL    = 5'd5;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_SRL    = 5'd6;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_SRA    = 5'd7;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_SLT    = 5'd8;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_SLTU   = 5'd9;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_MUL    = 5'd16;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_MULH   = 5'd17;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_MULHSU = 5'd18;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_MULHU  = 5'd19;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_DIV    = 5'd20;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_DIVU   = 5'd21;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_REM    = 5'd22;
  localparam logic [EXU_OPT_WIDTH-1:0] EXU_REMU   = 5'd23;

  // True for ops that must go through the multi-cycle mul/div unit.
  function automatic logic is_mext_op(input logic [EXU_OPT_WIDTH-1:0] op);
    return (op == EXU_MUL)  || (op == EXU_MULH) || (op == EXU_MULHSU) ||
           (op == EXU_MULHU)|| (op == EXU_DIV)  || (op == EXU_DIVU)   ||
           (op == EXU_REM)  || (op == EXU_REMU);
  endfunction

endpackage

// File: rtl/core_seq_ctrl_watchdog.sv
// Saturating wait-cycle counter: clear wins over enable, expired flags the limit.
module seq_watchdog #(
  parameter int          W   = 8,
  parameter int unsigned MAX = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [W-1:0] r_cnt;
  logic         w_at_max;

  assign w_at_max  = (r_cnt == W'(MAX));
  assign o_expired = w_at_max;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_max) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with bus watchdog, halt and
// cycle/retired-instruction counters. Handshake: a request is held until its ack.
module core_seq_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter int          CNT_W   = 32,
  parameter int          TMO_W   = 8,
  parameter int unsigned TMO_MAX = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  output logic                     o_ifu_req,
  input  logic                     i_ifu_ack,
  output logic                     o_ir_wren,
  input  logic [EXU_OPT_WIDTH-1:0] i_idu_exop,
  input  logic                     i_idu_lden,
  input  logic                     i_idu_sten,
  input  logic                     i_idu_rd_wren,
  input  logic                     i_idu_illegal,
  input  logic                     i_halt,
  output logic                     o_exu_start,
  input  logic                     i_exu_done,
  output logic                     o_lsu_req,
  output logic                     o_lsu_we,
  input  logic                     i_lsu_ack,
  output logic                     o_reg_wren,
  output logic                     o_pc_wren,
  output logic [2:0]               o_state,
  output logic                     o_halted,
  output logic [1:0]               o_err,
  output logic [CNT_W-1:0]         o_cycle_cnt,
  output logic [CNT_W-1:0]         o_instret
);

  ctrl_state_e      r_state;
  ctrl_state_e      w_next;
  logic [1:0]       r_err;
  logic [1:0]       w_err_next;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret;
  logic             w_tmo;
  logic             w_wd_en;
  logic             w_ifu_req;
  logic             w_ir_wren;
  logic             w_exu_start;
  logic             w_lsu_req;
  logic             w_lsu_we;
  logic             w_reg_wren;
  logic             w_pc_wren;

  assign w_wd_en = (r_state == CTRL_FETCH) || (r_state == CTRL_EXEC) ||
                   (r_state == CTRL_MEM);

  seq_watchdog #(
    .W   (TMO_W),
    .MAX (TMO_MAX)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (w_next != r_state),
    .i_en      (w_wd_en),
    .o_expired (w_tmo)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= CTRL_RESET;
      r_err   <= ERR_NONE;
    end else begin
      r_state <= w_next;
      r_err   <= w_err_next;
    end
  end

  // An ack on the final allowed wait cycle wins over the timeout.
  always_comb begin
    w_next      = r_state;
    w_err_next  = r_err;
    w_ifu_req   = 1'b0;
    w_ir_wren   = 1'b0;
    w_exu_start = 1'b0;
    w_lsu_req   = 1'b0;
    w_lsu_we    = 1'b0;
    w_reg_wren  = 1'b0;
    w_pc_wren   = 1'b0;
    case (r_state)
      CTRL_RESET: w_next = CTRL_FETCH;
      CTRL_FETCH: begin
        w_ifu_req = 1'b1;
        if (i_ifu_ack) begin
          w_ir_wren = 1'b1;
          w_next    = CTRL_DECODE;
        end else if (w_tmo) begin
          w_err_next = ERR_FETCH_TMO;
          w_next     = CTRL_HALT;
        end
      end
      CTRL_DECODE: begin
        if (i_idu_illegal) begin
          w_err_next = ERR_EXU;
          w_next     = CTRL_HALT;
        end else if (i_halt) begin
          w_next = CTRL_HALT;
        end else if (is_mext_op(i_idu_exop)) begin
          w_exu_start = 1'b1;
          w_next      = CTRL_EXEC;
        end else if (i_idu_lden || i_idu_sten) begin
          w_next = CTRL_MEM;
        end else begin
          w_next = CTRL_WB;
        end
      end
      CTRL_EXEC: begin
        if (i_exu_done) begin
          w_next = CTRL_WB;
        end else if (w_tmo) begin
          w_err_next = ERR_EXU;
          w_next     = CTRL_HALT;
        end
      end
      CTRL_MEM: begin
        w_lsu_req = 1'b1;
        w_lsu_we  = i_idu_sten;
        if (i_lsu_ack) begin
          w_next = CTRL_WB;
        end else if (w_tmo) begin
          w_err_next = ERR_LSU_TMO;
          w_next     = CTRL_HALT;
        end
      end
      CTRL_WB: begin
        w_reg_wren = i_idu_rd_wren & ~i_idu_sten;
        w_pc_wren  = 1'b1;
        w_next     = CTRL_FETCH;
      end
      CTRL_HALT: w_next = CTRL_HALT;
      default:   w_next = CTRL_RESET;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cycle_cnt <= '0;
      r_instret   <= '0;
    end else begin
      if ((r_state != CTRL_RESET) && (r_state != CTRL_HALT)) begin
        r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      end
      if (r_state == CTRL_WB) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  assign o_ifu_req   = w_ifu_req;
  assign o_ir_wren   = w_ir_wren;
  assign o_exu_start = w_exu_start;
  assign o_lsu_req   = w_lsu_req;
  assign o_lsu_we    = w_lsu_we;
  assign o_reg_wren  = w_reg_wren;
  assign o_pc_wren   = w_pc_wren;
  assign o_state     = r_state;
  assign o_halted    = (r_state == CTRL_HALT);
  assign o_err       = r_err;
  assign o_cycle_cnt = r_cycle_cnt;
  assign o_instret   = r_instret;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: per-cycle vector table plus hand-written
// sequences for mul/div, watchdog, halt, illegal and asynchronous reset.
module tb_core_seq_ctrl;
  import core_seq_ctrl_pkg::*;

  localparam int CNT_W = 32;
  localparam logic [2:0] S_RESET = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     ifu_req, ifu_ack, ir_wren;
  logic [EXU_OPT_WIDTH-1:0] exop;
  logic                     lden, sten, rd_wren, illegal, halt;
  logic                     exu_start, exu_done;
  logic                     lsu_req, lsu_we, lsu_ack;
  logic                     reg_wren, pc_wren, halted;
  logic [2:0]               state;
  logic [1:0]               err;
  logic [CNT_W-1:0]         cycle_cnt, instret;

  always #5 clk = ~clk;

  core_seq_ctrl dut (
    .i_clk(clk), .i_rst(rst_n),
    .o_ifu_req(ifu_req), .i_ifu_ack(ifu_ack), .o_ir_wren(ir_wren),
    .i_idu_exop(exop), .i_idu_lden(lden), .i_idu_sten(sten),
    .i_idu_rd_wren(rd_wren), .i_idu_illegal(illegal), .i_halt(halt),
    .o_exu_start(exu_start), .i_exu_done(exu_done),
    .o_lsu_req(lsu_req), .o_lsu_we(lsu_we), .i_lsu_ack(lsu_ack),
    .o_reg_wren(reg_wren), .o_pc_wren(pc_wren), .o_state(state),
    .o_halted(halted), .o_err(err), .o_cycle_cnt(cycle_cnt), .o_instret(instret)
  );

  typedef struct {
    logic                     ack;
    logic [EXU_OPT_WIDTH-1:0] op;
    logic                     ld, st, rd, ill, hlt, dn, lack;
    logic [2:0]               e_st;
    logic                     e_ireq, e_irw, e_xs, e_lreq, e_lwe, e_rw, e_pw;
  } vec_t;

  vec_t             vecs[$];
  logic [CNT_W-1:0] exp_q[$];
  logic [CNT_W-1:0] exp_instret = '0;
  int               n_vec = 0;
  int               n_miss = 0;
  int               n_start = 0;
  int               n_regw = 0;

  always @(posedge clk) begin
    if (exu_start) n_start <= n_start + 1;
    if (reg_wren)  n_regw  <= n_regw + 1;
  end

  function automatic vec_t mk(input logic a, input logic [EXU_OPT_WIDTH-1:0] o,
                              input logic l, s, r, i, h, d, la, input logic [2:0] es,
                              input logic ireq, irw, xs, lreq, lwe, rw, pw);
    vec_t v;
    v.ack = a; v.op = o; v.ld = l; v.st = s; v.rd = r; v.ill = i; v.hlt = h;
    v.dn = d; v.lack = la; v.e_st = es; v.e_ireq = ireq; v.e_irw = irw;
    v.e_xs = xs; v.e_lreq = lreq; v.e_lwe = lwe; v.e_rw = rw; v.e_pw = pw;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    ifu_ack = v.ack; exop = v.op; lden = v.ld; sten = v.st; rd_wren = v.rd;
    illegal = v.ill; halt = v.hlt; exu_done = v.dn; lsu_ack = v.lack;
  endtask

  task automatic clear_inputs();
    ifu_ack = 0; exop = EXU_ADD; lden = 0; sten = 0; rd_wren = 0;
    illegal = 0; halt = 0; exu_done = 0; lsu_ack = 0;
  endtask

  // Leaves the bench 1 time unit after the edge that enters FETCH.
  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state), 32'(S_RESET));
    chk("rst_reqs", {29'b0, ifu_req, lsu_req, exu_start}, 32'd0);
    chk("rst_strobes", {29'b0, ir_wren, reg_wren, pc_wren}, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cycle", cycle_cnt, 32'd0);
    chk("rst_instret", instret, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_instret = '0;
  endtask

  task automatic fetch_ok(input logic [EXU_OPT_WIDTH-1:0] op, input logic l, s, r, i, h);
    clear_inputs();
    ifu_ack = 1; exop = op; lden = l; sten = s; rd_wren = r; illegal = i; halt = h;
    @(negedge clk);
    chk("fetch_state", 32'(state), 32'(S_FETCH));
    chk("fetch_irw", 32'(ir_wren), 32'd1);
    @(posedge clk); #1;
    ifu_ack = 0;
  endtask

  task automatic run_alu();
    fetch_ok(EXU_ADD, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("alu_decode", 32'(state), 32'(S_DECODE));
    @(posedge clk); #1;
    @(negedge clk);
    chk("alu_wb", 32'(state), 32'(S_WB));
    chk("alu_regw", 32'(reg_wren), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    logic [CNT_W-1:0] frozen;
    int regw0;
    int start0;

    // ADD, zero-wait
    vecs.push_back(mk(1, EXU_ADD, 0,0,1,0,0,0,0, S_FETCH,  1,1,0,0,0,0,0));
    vecs.push_back(mk(0, EXU_ADD, 0,0,1,0,0,0,0, S_DECODE, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0, EXU_ADD, 0,0,1,0,0,0,0, S_WB,     0,0,0,0,0,1,1));
    // LW with ack after 4 wait cycles
    vecs.push_back(mk(1, EXU_ADD, 1,0,1,0,0,0,0, S_FETCH,  1,1,0,0,0,0,0));
    vecs.push_back(mk(0, EXU_ADD, 1,0,1,0,0,0,0, S_DECODE, 0,0,0,0,0,0,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, EXU_ADD, 1,0,1,0,0,0,0, S_MEM, 0,0,0,1,0,0,0));
    vecs.push_back(mk(0, EXU_ADD, 1,0,1,0,0,0,1, S_MEM,    0,0,0,1,0,0,0));
    vecs.push_back(mk(0, EXU_ADD, 1,0,1,0,0,0,0, S_WB,     0,0,0,0,0,1,1));
    // Fetch waits with a stray exu_done, then SW (rd_wren must be masked)
    vecs.push_back(mk(0, EXU_ADD, 0,0,0,0,0,1,0, S_FETCH,  1,0,0,0,0,0,0));
    vecs.push_back(mk(0, EXU_ADD, 0,0,0,0,0,1,0, S_FETCH,  1,0,0,0,0,0,0));
    vecs.push_back(mk(1, EXU_ADD, 0,1,1,0,0,0,0, S_FETCH,  1,1,0,0,0,0,0));
    vecs.push_back(mk(0, EXU_ADD, 0,1,1,0,0,0,0, S_DECODE, 0,0,0,0,0,0,0));
    vecs.push_back(mk(0, EXU_ADD, 0,1,1,0,0,0,1, S_MEM,    0,0,0,1,1,0,0));
    vecs.push_back(mk(0, EXU_ADD, 0,1,1,0,0,0,0, S_WB,     0,0,0,0,0,0,1));

    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].e_st));
      chk($sformatf("v%0d_ifu_req", i), 32'(ifu_req), 32'(vecs[i].e_ireq));
      chk($sformatf("v%0d_ir_wren", i), 32'(ir_wren), 32'(vecs[i].e_irw));
      chk($sformatf("v%0d_exu_start", i), 32'(exu_start), 32'(vecs[i].e_xs));
      chk($sformatf("v%0d_lsu_req", i), 32'(lsu_req), 32'(vecs[i].e_lreq));
      if (vecs[i].e_lreq) chk($sformatf("v%0d_lsu_we", i), 32'(lsu_we), 32'(vecs[i].e_lwe));
      chk($sformatf("v%0d_reg_wren", i), 32'(reg_wren), 32'(vecs[i].e_rw));
      chk($sformatf("v%0d_pc_wren", i), 32'(pc_wren), 32'(vecs[i].e_pw));
      if (vecs[i].e_pw) begin
        exp_instret++;
        exp_q.push_back(exp_instret);
      end
      @(posedge clk); #1;
      if (vecs[i].e_pw) chk($sformatf("v%0d_instret", i), instret, exp_q.pop_front());
    end
    // 3 + 1 + 1 + 6 + 2 + 1 + 1 + 1 + 1 = 17 counted cycles so far
    chk("cycle_after_table", cycle_cnt, 32'd17);

    // DIV: done on the 33rd EXEC cycle
    start0 = n_start;
    fetch_ok(EXU_DIV, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("div_decode", 32'(state), 32'(S_DECODE));
    chk("div_start", 32'(exu_start), 32'd1);
    @(posedge clk); #1;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      exu_done = (i == 33);
      @(negedge clk);
      if (state != S_EXEC) break;
      n++;
      @(posedge clk); #1;
    end
    exu_done = 0;
    chk("div_exec_cycles", 32'(n), 32'd33);
    chk("div_wb", 32'(state), 32'(S_WB));
    chk("div_regw", 32'(reg_wren), 32'd1);
    @(posedge clk); #1;
    chk("div_start_pulses", 32'(n_start - start0), 32'd1);
    chk("div_instret", instret, 32'd4);

    // Asynchronous reset in the middle of a load
    fetch_ok(EXU_ADD, 1, 0, 1, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_mem_req", 32'(lsu_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req_drop", 32'(lsu_req), 32'd0);
    chk("async_state", 32'(state), 32'(S_RESET));
    chk("async_instret", instret, 32'd0);
    do_reset();
    chk("post_rst_state", 32'(state), 32'(S_FETCH));
    chk("post_rst_cycle", cycle_cnt, 32'd0);

    // Ten ALU ops then ebreak
    regw0 = n_regw;
    for (int i = 0; i < 10; i++) run_alu();
    fetch_ok(EXU_ADD, 0, 0, 1, 0, 1);
    @(negedge clk);
    chk("ebreak_decode_regw", 32'(reg_wren), 32'd0);
    chk("ebreak_decode_pcw", 32'(pc_wren), 32'd0);
    @(posedge clk); #1;
    ifu_ack = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("ebreak_state", 32'(state), 32'(S_HALT));
    chk("ebreak_halted", 32'(halted), 32'd1);
    chk("ebreak_instret", instret, 32'd10);
    chk("ebreak_err", 32'(err), 32'd0);
    chk("ebreak_cycle", cycle_cnt, 32'd32);
    chk("ebreak_regw_total", 32'(n_regw - regw0), 32'd10);
    chk("halt_no_fetch", 32'(ifu_req | ir_wren), 32'd0);

    // Illegal beats ebreak and a mul/div op
    do_reset();
    fetch_ok(EXU_DIV, 0, 0, 1, 1, 1);
    @(negedge clk);
    chk("illegal_no_start", 32'(exu_start), 32'd0);
    @(posedge clk); #1;
    chk("illegal_state", 32'(state), 32'(S_HALT));
    chk("illegal_err", 32'(err), 32'd3);

    // Fetch ack on the last allowed wait cycle is accepted
    do_reset();
    repeat (255) @(posedge clk);
    #1 ifu_ack = 1;
    @(negedge clk);
    chk("fetch_late_irw", 32'(ir_wren), 32'd1);
    @(posedge clk); #1;
    ifu_ack = 0;
    chk("fetch_late_state", 32'(state), 32'(S_DECODE));
    chk("fetch_late_err", 32'(err), 32'd0);

    // Fetch timeout
    do_reset();
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!(state == S_FETCH && ifu_req)) break;
      n++;
      @(posedge clk); #1;
    end
    chk("fetch_tmo_cycles", 32'(n), 32'd256);
    chk("fetch_tmo_err", 32'(err), 32'd1);
    chk("fetch_tmo_halt", 32'(halted), 32'd1);
    chk("fetch_tmo_req", 32'(ifu_req), 32'd0);

    // LSU never acks
    do_reset();
    fetch_ok(EXU_ADD, 1, 0, 1, 0, 0);
    @(posedge clk); #1;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!(state == S_MEM && lsu_req)) break;
      n++;
      @(posedge clk); #1;
    end
    chk("lsu_tmo_cycles", 32'(n), 32'd256);
    chk("lsu_tmo_state", 32'(state), 32'(S_HALT));
    chk("lsu_tmo_err", 32'(err), 32'd2);
    chk("lsu_tmo_req", 32'(lsu_req), 32'd0);
    chk("lsu_tmo_cycle", cycle_cnt, 32'd258);
    frozen = cycle_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lsu_tmo_frozen", cycle_cnt, 32'd258);
    chk("lsu_tmo_err_hold", 32'(err), 32'd2);
    if (frozen !== cycle_cnt) $display("note: cycle counter moved while halted");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
